fxp_alu_sequencer: RTL and testbench

//  Valid/ready front end for the fixed-point datapath. Registers add/sub/mul results from the combinational

---
 rtl/fxp_pkg.sv | 28 ++
 rtl/fxp_alu_sequencer_if.sv | 25 ++
 rtl/fxp_alu.sv | 67 ++++++
 rtl/fxp_div_iter.sv | 57 +++++
 rtl/fxp_alu_sequencer.sv | 137 +++++++++++++
 tb/tb_fxp_alu_sequencer.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared op/state encodings and saturation limits for the fixed-point sequencer
package fxp_pkg;

    localparam int FXP_N = 32;
    localparam int FXP_Q = 12;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fxp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } fxp_state_e;

    function automatic logic [63:0] fxp_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fxp_min(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/fxp_alu_sequencer_if.sv
// rtl/fxp_alu_sequencer_if.sv - op request and result channels between issuer, sequencer and consumer
interface fxp_alu_sequencer_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic         out_ovf;
    logic         out_div0;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_div0
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_div0
    );
endinterface

// File: rtl/fxp_alu.sv
// rtl/fxp_alu.sv - combinational add/sub/mul with overflow; FXP_SAT_EN clamps overflowed results
module fxp_alu
    import fxp_pkg::*;
#(
    parameter int N = FXP_N,
    parameter int Q = FXP_Q
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  fxp_op_e      op,
    output logic [N-1:0] result,
    output logic         ovf
);
    logic [N-1:0]   sum;
    logic [N-1:0]   diff;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [2*N-1:0] mag_p;
    logic [2*N-1:0] prod_s;
    logic [N-1:0]   mul_res;
    logic           mul_ovf;

    assign sum   = a + b;
    assign diff  = a - b;
    assign mag_a = a[N-1] ? -a : a;
    assign mag_b = b[N-1] ? -b : b;
    // One unsigned multiplier; the signed product is recovered from the magnitude.
    assign mag_p   = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
    assign prod_s  = (a[N-1] ^ b[N-1]) ? -mag_p : mag_p;
    assign mul_res = N'(prod_s >> Q);
    assign mul_ovf = |(mag_p >> (N - 1 + Q));

`ifdef FXP_SAT_EN
    localparam logic [N-1:0] RES_MAX = N'(fxp_max(N));
    localparam logic [N-1:0] RES_MIN = N'(fxp_min(N));
    logic sat_neg;
`endif

    always_comb begin
        result = sum;
        ovf    = 1'b0;
`ifdef FXP_SAT_EN
        sat_neg = a[N-1];
`endif
        case (op)
            OP_SUB: begin
                result = diff;
                ovf    = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_MUL: begin
                result = mul_res;
                ovf    = mul_ovf;
`ifdef FXP_SAT_EN
                sat_neg = a[N-1] ^ b[N-1];
`endif
            end
            default: begin
                ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
        endcase
`ifdef FXP_SAT_EN
        if (ovf) begin
            result = sat_neg ? RES_MIN : RES_MAX;
        end
`endif
    end
endmodule

// File: rtl/fxp_div_iter.sv
// rtl/fxp_div_iter.sv - restoring unsigned divider, (dividend << Q) / divisor, one quotient bit per cycle
module fxp_div_iter #(
    parameter int N = 32,
    parameter int Q = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   dividend,
    input  logic [N-1:0]   divisor,
    output logic           done,
    output logic [N+Q-1:0] quot
);
    localparam int W  = N + Q;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  dvd;
    logic [N:0]    rem;
    logic [N-1:0]  dsr;
    logic [CW-1:0] cnt;
    logic          run;
    logic [N+1:0]  shifted;
    logic          ge;
    logic [N:0]    rem_next;

    // Quotient bits shift into the vacated low end of the dividend register.
    assign shifted  = {rem, dvd[W-1]};
    assign ge       = shifted >= {2'b00, dsr};
    assign rem_next = ge ? (N+1)'(shifted - {2'b00, dsr}) : (N+1)'(shifted);
    assign quot     = {dvd[W-2:0], ge};
    assign done     = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            dvd <= {dividend, {Q{1'b0}}};
            rem <= '0;
            dsr <= divisor;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            dvd <= quot;
            rem <= rem_next;
            if (done) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fxp_alu_sequencer.sv
// rtl/fxp_alu_sequencer.sv - valid/ready fixed-point op sequencer; FXP_SAT_EN clamps overflowed results
module fxp_alu_sequencer
    import fxp_pkg::*;
#(
    parameter int N = FXP_N,
    parameter int Q = FXP_Q
) (
    input  logic                 clk,
    input  logic                 rst,
    fxp_alu_sequencer_if.slave   bus,
    output logic                 busy
);
    localparam logic [N-1:0]   RES_MAX   = N'(fxp_max(N));
    localparam logic [N-1:0]   RES_MIN   = N'(fxp_min(N));
    localparam logic [N+Q-1:0] Q_MAX_POS = (N+Q)'(fxp_max(N));
    localparam logic [N+Q-1:0] Q_MAX_NEG = (N+Q)'(fxp_min(N));

    fxp_state_e     state;
    logic           out_valid_q;
    logic [N-1:0]   result_q;
    logic           ovf_q;
    logic           div0_q;
    logic           div_neg;

    fxp_op_e        op;
    logic           accept;
    logic           b_zero;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [N-1:0]   alu_res;
    logic           alu_ovf;
    logic           div_start;
    logic           div_done;
    logic [N+Q-1:0] div_quot;
    logic [N-1:0]   imm_res;
    logic           imm_ovf;
    logic           imm_div0;
    logic [N-1:0]   dq_res;
    logic           dq_ovf;

    assign op           = fxp_op_e'(bus.in_op);
    assign bus.in_ready = !rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign b_zero       = (bus.in_b == '0);
    assign mag_a        = bus.in_a[N-1] ? -bus.in_a : bus.in_a;
    assign mag_b        = bus.in_b[N-1] ? -bus.in_b : bus.in_b;
    assign div_start    = accept && (op == OP_DIV) && !b_zero;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_div0   = div0_q;
    assign busy           = (state != IDLE);

    fxp_alu #(.N(N), .Q(Q)) u_alu (
        .a      (bus.in_a),
        .b      (bus.in_b),
        .op     (op),
        .result (alu_res),
        .ovf    (alu_ovf)
    );

    fxp_div_iter #(.N(N), .Q(Q)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (mag_a),
        .divisor  (mag_b),
        .done     (div_done),
        .quot     (div_quot)
    );

    // Single-cycle results; a divide reaching here has b==0.
    always_comb begin
        imm_res  = alu_res;
        imm_ovf  = alu_ovf;
        imm_div0 = 1'b0;
        if (op == OP_DIV) begin
            imm_res  = bus.in_a[N-1] ? RES_MIN : RES_MAX;
            imm_ovf  = 1'b1;
            imm_div0 = 1'b1;
        end
    end

    // -2^(N-1) is representable, so the negative limit is one larger in magnitude.
    always_comb begin
        dq_ovf = div_neg ? (div_quot > Q_MAX_NEG) : (div_quot > Q_MAX_POS);
        dq_res = div_neg ? -div_quot[N-1:0] : div_quot[N-1:0];
`ifdef FXP_SAT_EN
        if (dq_ovf) begin
            dq_res = div_neg ? RES_MIN : RES_MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
            div_neg     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if ((state == DONE) && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                    if (accept) begin
                        if ((op == OP_DIV) && !b_zero) begin
                            state   <= DIV;
                            div_neg <= bus.in_a[N-1] ^ bus.in_b[N-1];
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= imm_res;
                            ovf_q       <= imm_ovf;
                            div0_q      <= imm_div0;
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= dq_res;
                        ovf_q       <= dq_ovf;
                        div0_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fxp_alu_sequencer.sv
// tb/tb_fxp_alu_sequencer.sv - scoreboard bench for fxp_alu_sequencer; expectations follow FXP_SAT_EN
module tb_fxp_alu_sequencer;
    import fxp_pkg::*;

    localparam int N = 32;
    localparam int Q = 12;
`ifdef FXP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        div0;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic        ovf;
        logic        div0;
        int          lat;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    fxp_alu_sequencer_if #(.N(N)) bus ();

    fxp_alu_sequencer #(.N(N), .Q(Q)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] res, input logic ovf, input logic div0,
                        input string name, input bit push);
        int waited;
        if (push) sb.push_back('{res, ovf, div0, name});
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: in_ready never rose within 200 cycles", name);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic measure_latency(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge with valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got 0x%08h with nothing expected", bus.out_result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, bus.out_result, e.res);
                    check({e.name, "_ovf"}, 32'(bus.out_ovf), 32'(e.ovf));
                    check({e.name, "_div0"}, 32'(bus.out_div0), 32'(e.div0));
                end
            end
        end
    end

    initial begin
        int cyc;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        vecs.push_back('{32'h0000_1800, 32'h0000_2000, OP_MUL, 32'h0000_3000, 1'b0, 1'b0, 0,  "mul_1p5x2"});
        vecs.push_back('{32'h0000_3000, 32'h0000_2000, OP_DIV, 32'h0000_1800, 1'b0, 1'b0, 44, "div_3by2"});
        vecs.push_back('{32'hFFFF_D000, 32'h0000_2000, OP_DIV, 32'hFFFF_E800, 1'b0, 1'b0, 44, "div_neg3by2"});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD,
                         SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1, 1'b0, 0, "add_ovf"});
        vecs.push_back('{32'hFFFF_0000, 32'h0000_0000, OP_DIV, 32'h8000_0000, 1'b1, 1'b1, 0, "div0_neg"});
        vecs.push_back('{32'h0001_0000, 32'h0000_0000, OP_DIV, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, "div0_pos"});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, OP_SUB,
                         SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b0, 0, "sub_ovf"});
        vecs.push_back('{32'h0000_1000, 32'h0000_3000, OP_SUB, 32'hFFFF_E000, 1'b0, 1'b0, 0, "sub_neg"});
        vecs.push_back('{32'hFFFF_F000, 32'h0000_3000, OP_MUL, 32'hFFFF_D000, 1'b0, 1'b0, 0, "mul_neg"});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_2000, OP_MUL,
                         SAT ? 32'h7FFF_FFFF : 32'hFFFF_FFFE, 1'b1, 1'b0, 0, "mul_ovf"});
        vecs.push_back('{32'h4000_0000, 32'h0000_0800, OP_DIV,
                         SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1, 1'b0, 44, "div_ovf_pos"});
        vecs.push_back('{32'hC000_0000, 32'h0000_0800, OP_DIV, 32'h8000_0000, 1'b0, 1'b0, 44, "div_min_neg"});
        vecs.push_back('{32'h0000_1000, 32'h0000_3000, OP_DIV, 32'h0000_0555, 1'b0, 1'b0, 44, "div_third"});
        vecs.push_back('{32'hFFFF_F000, 32'h0000_3000, OP_DIV, 32'hFFFF_FAAB, 1'b0, 1'b0, 44, "div_neg_third"});

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        check("rst_out_div0", 32'(bus.out_div0), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].ovf, vecs[i].div0, vecs[i].name, 1'b1);
            measure_latency(cyc);
            check({vecs[i].name, "_latency"}, 32'(cyc), 32'(vecs[i].lat));
        end

        // Consumer stall: result and flags must hold, no new op accepted.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(32'h0000_1000, 32'h0000_2000, OP_ADD, 32'h0000_3000, 1'b0, 1'b0, "stall_add", 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_result", bus.out_result, 32'h0000_3000);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(32'h0000_1000, 32'h0000_1000, OP_ADD, 32'h0000_2000, 1'b0, 1'b0, "b2b_add", 1'b1);
        check("b2b_out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_out_result", bus.out_result, 32'h0000_2000);

        // Reset during a divide discards it.
        @(posedge clk);
        #1;
        send(32'h0000_3000, 32'h0000_2000, OP_DIV, 32'h0, 1'b0, 1'b0, "aborted_div", 1'b0);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("div_busy", 32'(busy), 32'd1);
        check("div_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        send(32'h0000_1000, 32'h0000_1000, OP_ADD, 32'h0000_2000, 1'b0, 1'b0, "post_abort_add", 1'b1);
        measure_latency(cyc);
        check("post_abort_latency", 32'(cyc), 32'd0);

        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (60) @(posedge clk);
        #1;
        check("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
